// File: rtl/hsv_sequencer.sv
// Effect sequencer ahead of the HSV-to-RGB converter: timebase, debounced mode
// button and rainbow / colour-breathe / white-breathe / static effects on h/s/v.
module hsv_sequencer #(
   parameter int TICK_DIV       = 135000,
   parameter int DEBOUNCE_TICKS = 4,
   parameter int V_MIN          = 16
) (
   input  logic       sys_clk,
   input  logic       sys_rst_n,
   input  logic       btn_n,
   output logic [7:0] h,
   output logic [7:0] s,
   output logic [7:0] v,
   output logic [1:0] mode,
   output logic       update
);

   localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int DB_W  = $clog2(DEBOUNCE_TICKS + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);
   localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE_TICKS);
   localparam logic [7:0]       VMIN8    = 8'(V_MIN);

   typedef enum logic [1:0] {
      RAINBOW = 2'd0,
      BREATHE = 2'd1,
      WHITE   = 2'd2,
      STATIC  = 2'd3
   } mode_e;

   typedef enum logic {DB_RELEASED, DB_PRESSED} db_state_e;
   typedef enum logic {DIR_DOWN, DIR_UP}        dir_e;

   typedef struct packed {
      logic [7:0] h;
      logic [7:0] s;
      logic [7:0] v;
      mode_e      mode;
      dir_e       dir;
   } fx_t;

   // ---------------------------------------------------------------- timebase
   logic [CNT_W-1:0] tick_cnt;
   logic             tick;

   assign tick = (tick_cnt == CNT_LAST);

   always_ff @(posedge sys_clk) begin
      if (!sys_rst_n)  tick_cnt <= '0;
      else if (tick)   tick_cnt <= '0;
      else             tick_cnt <= tick_cnt + 1'b1;
   end

   // ------------------------------------------------------------ synchronizer
   logic [1:0] sync_q;
   logic       btn_lvl;

   always_ff @(posedge sys_clk) begin
      if (!sys_rst_n) sync_q <= 2'b11;
      else            sync_q <= {sync_q[0], btn_n};
   end

   assign btn_lvl = sync_q[1];

   // --------------------------------------------------------------- debouncer
   db_state_e       db_q, db_nx;
   logic [DB_W-1:0] dbc_q, dbc_nx, dbc_inc;
   logic            db_target;
   logic            press;

   assign dbc_inc = dbc_q + 1'b1;

   always_ff @(posedge sys_clk) begin
      if (!sys_rst_n) begin
         db_q  <= DB_RELEASED;
         dbc_q <= '0;
      end else begin
         db_q  <= db_nx;
         dbc_q <= dbc_nx;
      end
   end

   // Released counts low samples, pressed counts high samples; any sample at
   // the other level restarts the run.
   always_comb begin
      db_nx     = db_q;
      dbc_nx    = dbc_q;
      press     = 1'b0;
      db_target = (db_q == DB_PRESSED);
      if (tick) begin
         if (btn_lvl == db_target) begin
            if (dbc_inc == DB_LAST) begin
               db_nx  = (db_q == DB_RELEASED) ? DB_PRESSED : DB_RELEASED;
               dbc_nx = '0;
               press  = (db_q == DB_RELEASED);
            end else begin
               dbc_nx = dbc_inc;
            end
         end else begin
            dbc_nx = '0;
         end
      end
   end

   // ----------------------------------------------------------- effect engine
   fx_t   fx_q, fx_nx;
   mode_e mode_adv;
   logic  update_nx;

   assign mode_adv = mode_e'(fx_q.mode + 2'd1);

   always_ff @(posedge sys_clk) begin
      if (!sys_rst_n) begin
         fx_q   <= '{h: 8'd0, s: 8'd255, v: 8'd255, mode: RAINBOW, dir: DIR_DOWN};
         update <= 1'b0;
      end else begin
         fx_q   <= fx_nx;
         update <= update_nx;
      end
   end

   always_comb begin
      fx_nx = fx_q;
      if (tick) begin
         if (press) begin
            // A press tick only loads the entry values of the next effect.
            fx_nx.mode = mode_adv;
            fx_nx.s    = 8'd255;
            fx_nx.v    = 8'd255;
            case (mode_adv)
               BREATHE: fx_nx.dir = DIR_DOWN;
               WHITE: begin
                  fx_nx.s   = 8'd0;
                  fx_nx.dir = DIR_DOWN;
               end
               default: ;
            endcase
         end else begin
            case (fx_q.mode)
               RAINBOW: fx_nx.h = fx_q.h + 8'd1;
               BREATHE, WHITE: begin
                  if (fx_q.dir == DIR_DOWN) begin
                     if (fx_q.v == VMIN8) begin
                        fx_nx.dir = DIR_UP;
                        fx_nx.v   = VMIN8 + 8'd1;
                     end else begin
                        fx_nx.v   = fx_q.v - 8'd1;
                     end
                  end else begin
                     if (fx_q.v == 8'd255) begin
                        fx_nx.dir = DIR_DOWN;
                        fx_nx.v   = 8'd254;
                     end else begin
                        fx_nx.v   = fx_q.v + 8'd1;
                     end
                  end
               end
               default: ;
            endcase
         end
      end
   end

   // Direction is internal, so it does not count as a visible change.
   assign update_nx = (fx_nx.h != fx_q.h) || (fx_nx.s != fx_q.s) ||
                      (fx_nx.v != fx_q.v) || (fx_nx.mode != fx_q.mode);

   assign h    = fx_q.h;
   assign s    = fx_q.s;
   assign v    = fx_q.v;
   assign mode = fx_q.mode;

endmodule

// File: tb/tb_hsv_sequencer.sv
// Directed bench for hsv_sequencer: per-tick vector table plus hand sequences
// for reset, rainbow wrap, static hold and reset mid-operation.
module tb_hsv_sequencer;

   logic       sys_clk;
   logic       sys_rst_n;
   logic       btn_n;
   logic [7:0] h, s, v;
   logic [1:0] mode;
   logic       update;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic       btn_n;
      logic [7:0] h;
      logic [7:0] s;
      logic [7:0] v;
      logic [1:0] mode;
      logic       upd;
   } vec_t;

   vec_t tbl[$];

   hsv_sequencer #(
      .TICK_DIV      (4),
      .DEBOUNCE_TICKS(2),
      .V_MIN         (250)
   ) dut (
      .sys_clk  (sys_clk),
      .sys_rst_n(sys_rst_n),
      .btn_n    (btn_n),
      .h        (h),
      .s        (s),
      .v        (v),
      .mode     (mode),
      .update   (update)
   );

   initial sys_clk = 1'b0;
   always #5 sys_clk = ~sys_clk;

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic chk_all(input string tag, input logic [7:0] eh, input logic [7:0] es,
                          input logic [7:0] ev, input logic [1:0] em, input logic eu);
      chk({tag, " h"}, h, eh);
      chk({tag, " s"}, s, es);
      chk({tag, " v"}, v, ev);
      chk({tag, " mode"}, {6'd0, mode}, {6'd0, em});
      chk({tag, " update"}, {7'd0, update}, {7'd0, eu});
   endtask

   // Called just after a tick edge: the next tick lands 4 edges later.
   task automatic tick_step();
      @(posedge sys_clk); #1;
      chk("update one-cycle", {7'd0, update}, 8'd0);
      repeat (3) @(posedge sys_clk);
      #1;
   endtask

   task automatic add(input logic b, input logic [7:0] eh, input logic [7:0] es,
                      input logic [7:0] ev, input logic [1:0] em, input logic eu);
      vec_t r;
      r.btn_n = b; r.h = eh; r.s = es; r.v = ev; r.mode = em; r.upd = eu;
      tbl.push_back(r);
   endtask

   task automatic run_rows(input int first, input int last);
      for (int i = first; i <= last; i++) begin
         btn_n = tbl[i].btn_n;
         tick_step();
         chk_all($sformatf("row%0d", i), tbl[i].h, tbl[i].s, tbl[i].v, tbl[i].mode, tbl[i].upd);
      end
   endtask

   // Reset is applied at the current time and held across 3 edges.
   task automatic do_reset(input string tag);
      sys_rst_n = 1'b0;
      repeat (3) @(posedge sys_clk);
      #1;
      chk_all({tag, " in reset"}, 8'd0, 8'd255, 8'd255, 2'd0, 1'b0);
      sys_rst_n = 1'b1;
      repeat (3) @(posedge sys_clk);
      #1;
      chk_all({tag, " pre-tick"}, 8'd0, 8'd255, 8'd255, 2'd0, 1'b0);
      @(posedge sys_clk); #1;
      chk_all({tag, " first tick"}, 8'd1, 8'd255, 8'd255, 2'd0, 1'b1);
   endtask

   initial begin
      // btn_n set before a step is sampled on that step's tick.
      //  btn  h      s       v       mode upd
      add(0, 8'd1, 8'd255, 8'd255, 2'd0, 1);  // 0  count 1
      add(1, 8'd2, 8'd255, 8'd255, 2'd0, 1);  // 1  1-tick glitch dropped
      add(0, 8'd3, 8'd255, 8'd255, 2'd0, 1);  // 2
      add(0, 8'd3, 8'd255, 8'd255, 2'd1, 1);  // 3  press -> BREATHE
      add(0, 8'd3, 8'd255, 8'd254, 2'd1, 1);  // 4  held: no repeat
      add(0, 8'd3, 8'd255, 8'd253, 2'd1, 1);  // 5
      add(0, 8'd3, 8'd255, 8'd252, 2'd1, 1);  // 6
      add(1, 8'd3, 8'd255, 8'd251, 2'd1, 1);  // 7  release count 1
      add(0, 8'd3, 8'd255, 8'd250, 2'd1, 1);  // 8  bounce clears
      add(1, 8'd3, 8'd255, 8'd251, 2'd1, 1);  // 9  turn up
      add(1, 8'd3, 8'd255, 8'd252, 2'd1, 1);  // 10 released
      add(1, 8'd3, 8'd255, 8'd253, 2'd1, 1);  // 11
      add(1, 8'd3, 8'd255, 8'd254, 2'd1, 1);  // 12
      add(1, 8'd3, 8'd255, 8'd255, 2'd1, 1);  // 13
      add(1, 8'd3, 8'd255, 8'd254, 2'd1, 1);  // 14 turn down
      add(0, 8'd3, 8'd255, 8'd253, 2'd1, 1);  // 15
      add(0, 8'd3, 8'd0,   8'd255, 2'd2, 1);  // 16 press -> WHITE
      add(1, 8'd3, 8'd0,   8'd254, 2'd2, 1);  // 17
      add(1, 8'd3, 8'd0,   8'd253, 2'd2, 1);  // 18
      add(0, 8'd3, 8'd0,   8'd252, 2'd2, 1);  // 19
      add(0, 8'd3, 8'd255, 8'd255, 2'd3, 1);  // 20 press -> STATIC
      add(1, 8'd3, 8'd255, 8'd255, 2'd3, 0);  // 21
      add(1, 8'd3, 8'd255, 8'd255, 2'd3, 0);  // 22
      add(0, 8'd3, 8'd255, 8'd255, 2'd3, 0);  // 23
      add(0, 8'd3, 8'd255, 8'd255, 2'd0, 1);  // 24 press -> RAINBOW
      add(1, 8'd4, 8'd255, 8'd255, 2'd0, 1);  // 25 resumes from frozen h
      add(1, 8'd5, 8'd255, 8'd255, 2'd0, 1);  // 26
      add(0, 8'd6, 8'd255, 8'd255, 2'd0, 1);  // 27
      add(0, 8'd6, 8'd255, 8'd255, 2'd1, 1);  // 28 press -> BREATHE
      add(1, 8'd6, 8'd255, 8'd254, 2'd1, 1);  // 29
      add(1, 8'd6, 8'd255, 8'd253, 2'd1, 1);  // 30
      add(1, 8'd6, 8'd255, 8'd252, 2'd1, 1);  // 31
      add(1, 8'd6, 8'd255, 8'd251, 2'd1, 1);  // 32
      add(1, 8'd6, 8'd255, 8'd250, 2'd1, 1);  // 33
      add(1, 8'd6, 8'd255, 8'd251, 2'd1, 1);  // 34 dir up
      add(0, 8'd6, 8'd255, 8'd252, 2'd1, 1);  // 35 half-counted press

      sys_rst_n = 1'b0;
      btn_n     = 1'b1;
      #1;
      do_reset("reset");

      for (int i = 2; i <= 256; i++) begin
         tick_step();
         chk($sformatf("rainbow h%0d", i), h, 8'(i));
         chk($sformatf("rainbow upd%0d", i), {7'd0, update}, 8'd1);
      end
      chk("rainbow mode", {6'd0, mode}, 8'd0);

      run_rows(0, 22);

      btn_n = 1'b1;
      for (int i = 0; i < 20; i++) begin
         tick_step();
         chk($sformatf("static upd%0d", i), {7'd0, update}, 8'd0);
         chk($sformatf("static v%0d", i), v, 8'd255);
         chk($sformatf("static h%0d", i), h, 8'd3);
      end

      run_rows(23, 35);

      // Reset mid-breathe, off the tick phase, with a press half-counted.
      btn_n = 1'b1;
      @(posedge sys_clk);
      @(posedge sys_clk); #1;
      do_reset("midreset");
      for (int i = 2; i <= 4; i++) begin
         tick_step();
         chk_all($sformatf("post-reset t%0d", i), 8'(i), 8'd255, 8'd255, 2'd0, 1'b1);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
